// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM for the 16-bit, 4-bit-opcode CPU,
//               with memory wait states, halt and a retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int         CNT_W   = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             imem_rd,
    output logic             irwrite,
    output logic             pcwrite,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucs,
    output logic             selscrB,
    output logic             redges,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             flagwrite,
    output logic             dmem_rd,
    output logic             wren,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMRD  = 3'd4,
        S_MEMWR  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t           r_state;
    logic [3:0]       r_op_q;
    logic [CNT_W-1:0] r_count;

    logic             w_ctrl_xfer;
    logic             w_retire;
    logic [2:0]       w_alu;
    logic             w_selb;
    logic             w_redges;

    always_comb begin
        w_ctrl_xfer = (r_op_q == 4'd7) || (r_op_q == 4'd13) || (r_op_q == 4'd14);
        w_retire    = ((r_state == S_EXEC) && w_ctrl_xfer)
                   || ((r_state == S_MEMWR) && mem_ready)
                   || (r_state == S_WB);
    end

    // Datapath selects shared by EXEC and WB so writeback sees a stable ALU result
    always_comb begin
        w_alu    = 3'd2;
        w_selb   = 1'b0;
        w_redges = 1'b0;
        if (r_op_q <= 4'd6) begin
            w_alu    = r_op_q[2:0];
            w_redges = 1'b1;
        end else if ((r_op_q >= 4'd8) && (r_op_q <= 4'd10)) begin
            w_alu  = r_op_q[2:0];
            w_selb = 1'b1;
        end else if ((r_op_q == 4'd11) || (r_op_q == 4'd12)) begin
            w_selb = 1'b1;
        end else if ((r_op_q == 4'd13) || (r_op_q == 4'd14)) begin
            w_alu = 3'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op_q  <= 4'd0;
            r_count <= '0;
        end else begin
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
            case (r_state)
                S_IDLE:   if (run) r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_op_q  <= op;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= (r_op_q == HALT_OP) ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (w_ctrl_xfer)
                        r_state <= run ? S_FETCH : S_IDLE;
                    else if (r_op_q == 4'd11)
                        r_state <= S_MEMRD;
                    else if (r_op_q == 4'd12)
                        r_state <= S_MEMWR;
                    else
                        r_state <= S_WB;
                end
                S_MEMRD:  if (mem_ready) r_state <= S_WB;
                S_MEMWR:  if (mem_ready) r_state <= run ? S_FETCH : S_IDLE;
                S_WB:     r_state <= run ? S_FETCH : S_IDLE;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_rd   = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        pcsrc     = 2'd0;
        alucs     = 3'd0;
        selscrB   = 1'b0;
        redges    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        flagwrite = 1'b0;
        dmem_rd   = 1'b0;
        wren      = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_rd = 1'b1;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_EXEC: begin
                alucs     = w_alu;
                selscrB   = w_selb;
                redges    = w_redges;
                flagwrite = r_op_q inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd10};
                if (r_op_q == 4'd13) begin
                    pcwrite = zero;
                    pcsrc   = 2'd1;
                end else if (r_op_q == 4'd14) begin
                    pcwrite = ~zero;
                    pcsrc   = 2'd1;
                end else if (r_op_q == 4'd7) begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'd2;
                end
            end
            S_MEMRD: begin
                dmem_rd = 1'b1;
                alucs   = 3'd2;
                selscrB = 1'b1;
            end
            S_MEMWR: begin
                wren    = 1'b1;
                alucs   = 3'd2;
                selscrB = 1'b1;
            end
            S_WB: begin
                regwrite = 1'b1;
                alucs    = w_alu;
                selscrB  = w_selb;
                redges   = w_redges;
                memtoreg = (r_op_q == 4'd11);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Table-driven, directed and randomized checks of multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;

    logic        clk = 1'b0;
    logic        rst, run, zero, mem_ready;
    logic [3:0]  op;

    logic        imem_rd, irwrite, pcwrite, selscrB, redges, memtoreg;
    logic        regwrite, flagwrite, dmem_rd, wren, halted;
    logic [1:0]  pcsrc;
    logic [2:0]  alucs, state;
    logic [15:0] instr_count;

    logic        imem_rd_b, irwrite_b, pcwrite_b, selscrB_b, redges_b, memtoreg_b;
    logic        regwrite_b, flagwrite_b, dmem_rd_b, wren_b, halted_b;
    logic [1:0]  pcsrc_b;
    logic [2:0]  alucs_b, state_b;
    logic [3:0]  instr_count_b;

    logic [18:0] act, act_b;
    logic [15:0] mcnt;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    multicycle_ctrl u_dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .imem_rd(imem_rd), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
        .alucs(alucs), .selscrB(selscrB), .redges(redges), .memtoreg(memtoreg),
        .regwrite(regwrite), .flagwrite(flagwrite), .dmem_rd(dmem_rd), .wren(wren),
        .halted(halted), .state(state), .instr_count(instr_count)
    );

    // Narrow counter instance makes the all-ones -> zero wrap reachable quickly
    multicycle_ctrl #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .imem_rd(imem_rd_b), .irwrite(irwrite_b), .pcwrite(pcwrite_b), .pcsrc(pcsrc_b),
        .alucs(alucs_b), .selscrB(selscrB_b), .redges(redges_b), .memtoreg(memtoreg_b),
        .regwrite(regwrite_b), .flagwrite(flagwrite_b), .dmem_rd(dmem_rd_b), .wren(wren_b),
        .halted(halted_b), .state(state_b), .instr_count(instr_count_b)
    );

    assign act   = {imem_rd, irwrite, pcwrite, pcsrc, alucs, selscrB, redges, memtoreg,
                    regwrite, flagwrite, dmem_rd, wren, halted, state};
    assign act_b = {imem_rd_b, irwrite_b, pcwrite_b, pcsrc_b, alucs_b, selscrB_b, redges_b,
                    memtoreg_b, regwrite_b, flagwrite_b, dmem_rd_b, wren_b, halted_b, state_b};

    function automatic logic [18:0] ev(input logic imem, irw, pcw, input logic [1:0] pcs,
                                       input logic [2:0] alu, input logic selb, red, m2r,
                                       rw, fw, drd, wr, hlt, input logic [2:0] st);
        return {imem, irw, pcw, pcs, alu, selb, red, m2r, rw, fw, drd, wr, hlt, st};
    endfunction

    function automatic logic [18:0] e_fetch(input logic mr);
        return ev(L1, mr, mr, 2'd0, 3'd0, L0, L0, L0, L0, L0, L0, L0, L0, 3'd1);
    endfunction

    localparam logic [18:0] E_IDLE  = 19'd0;
    localparam logic [18:0] E_DEC   = 19'd2;
    localparam logic [18:0] E_MEMRD = {3'b000, 2'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4};
    localparam logic [18:0] E_MEMWR = {3'b000, 2'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5};
    localparam logic [18:0] E_HALT  = {3'b000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};

    // ALU/B-source/dest-field selects an opcode asks of the datapath
    function automatic void dp_fields(input logic [3:0] o, output logic [2:0] a,
                                      output logic b, output logic r);
        a = 3'd2; b = L0; r = L0;
        if (o <= 4'd6) begin
            a = o[2:0]; r = L1;
        end else if (o >= 4'd8 && o <= 4'd10) begin
            a = o[2:0]; b = L1;
        end else if (o == 4'd11 || o == 4'd12) begin
            b = L1;
        end else if (o == 4'd13 || o == 4'd14) begin
            a = 3'd3;
        end
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic cyc(input logic i_rst, input logic i_run, input logic [3:0] i_op,
                       input logic i_z, input logic i_mr, input logic [18:0] exp,
                       input logic [15:0] expc, input string nm);
        rst = i_rst; run = i_run; op = i_op; zero = i_z; mem_ready = i_mr;
        @(negedge clk);
        n_total++;
        if (act !== exp || act_b !== exp)
            $display("FAIL %s outputs: got %h / %h, expected %h", nm, act, act_b, exp);
        else
            n_pass++;
        n_total++;
        if (instr_count !== expc || instr_count_b !== expc[3:0])
            $display("FAIL %s count: got %0d / %0d, expected %0d / %0d",
                     nm, instr_count, instr_count_b, expc, expc[3:0]);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH back to FETCH, with fw fetch waits and mw memory waits
    task automatic instr(input logic [3:0] o, input logic z, input int fw, input int mw,
                         input logic run_after, input string nm);
        logic [2:0] a;
        logic       b, r, fl, pw, xfer;
        logic [1:0] ps;
        dp_fields(o, a, b, r);
        fl   = (o == 4'd2 || o == 4'd3 || o == 4'd5 || o == 4'd6 || o == 4'd10);
        xfer = (o == 4'd7 || o == 4'd13 || o == 4'd14);
        pw   = (o == 4'd7) ? L1 : (o == 4'd13) ? z : (o == 4'd14) ? ~z : L0;
        ps   = (o == 4'd7) ? 2'd2 : (o == 4'd13 || o == 4'd14) ? 2'd1 : 2'd0;
        for (int i = 0; i < fw; i++)
            cyc(L0, rbit(), rop(), rbit(), L0, e_fetch(L0), mcnt, nm);
        cyc(L0, rbit(), o, rbit(), L1, e_fetch(L1), mcnt, nm);
        cyc(L0, rbit(), rop(), rbit(), rbit(), E_DEC, mcnt, nm);
        cyc(L0, xfer ? run_after : rbit(), rop(), z, rbit(),
            ev(L0, L0, pw, ps, a, b, r, L0, L0, fl, L0, L0, L0, 3'd3), mcnt, nm);
        if (xfer) begin
            mcnt++;
        end else if (o == 4'd12) begin
            for (int i = 0; i < mw; i++)
                cyc(L0, rbit(), rop(), rbit(), L0, E_MEMWR, mcnt, nm);
            cyc(L0, run_after, rop(), rbit(), L1, E_MEMWR, mcnt, nm);
            mcnt++;
        end else begin
            if (o == 4'd11) begin
                for (int i = 0; i < mw; i++)
                    cyc(L0, rbit(), rop(), rbit(), L0, E_MEMRD, mcnt, nm);
                cyc(L0, rbit(), rop(), rbit(), L1, E_MEMRD, mcnt, nm);
            end
            cyc(L0, run_after, rop(), rbit(), rbit(),
                ev(L0, L0, L0, 2'd0, a, b, r, (o == 4'd11), L1, L0, L0, L0, L0, 3'd6), mcnt, nm);
            mcnt++;
        end
        if (!run_after) begin
            cyc(L0, L0, rop(), rbit(), rbit(), E_IDLE, mcnt, nm);
            cyc(L0, L1, rop(), rbit(), rbit(), E_IDLE, mcnt, nm);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic        z;
        logic        mr;
        logic [18:0] exp;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{L1, L0, 4'h0, L0, L0, E_IDLE, 16'd0};
        tbl[1]  = '{L0, L1, 4'h0, L0, L0, E_IDLE, 16'd0};
        tbl[2]  = '{L0, L1, 4'h2, L0, L1, e_fetch(L1), 16'd0};
        tbl[3]  = '{L0, L1, 4'h0, L0, L1, E_DEC, 16'd0};
        tbl[4]  = '{L0, L1, 4'h0, L1, L1, ev(L0, L0, L0, 2'd0, 3'd2, L0, L1, L0, L0, L1, L0, L0, L0, 3'd3), 16'd0};
        tbl[5]  = '{L0, L0, 4'h0, L0, L1, ev(L0, L0, L0, 2'd0, 3'd2, L0, L1, L0, L1, L0, L0, L0, L0, 3'd6), 16'd0};
        tbl[6]  = '{L0, L0, 4'h0, L0, L1, E_IDLE, 16'd1};
        tbl[7]  = '{L0, L1, 4'h0, L0, L0, E_IDLE, 16'd1};
        tbl[8]  = '{L0, L1, 4'hB, L0, L0, e_fetch(L0), 16'd1};
        tbl[9]  = '{L0, L1, 4'hB, L0, L1, e_fetch(L1), 16'd1};
        tbl[10] = '{L0, L1, 4'h0, L0, L1, E_DEC, 16'd1};
        tbl[11] = '{L0, L1, 4'h0, L1, L1, ev(L0, L0, L0, 2'd0, 3'd2, L1, L0, L0, L0, L0, L0, L0, L0, 3'd3), 16'd1};
        tbl[12] = '{L0, L1, 4'h0, L0, L0, E_MEMRD, 16'd1};
        tbl[13] = '{L0, L1, 4'h0, L0, L1, E_MEMRD, 16'd1};
        tbl[14] = '{L0, L0, 4'h0, L0, L0, ev(L0, L0, L0, 2'd0, 3'd2, L1, L0, L1, L1, L0, L0, L0, L0, 3'd6), 16'd1};
        tbl[15] = '{L0, L0, 4'h0, L0, L0, E_IDLE, 16'd2};

        rst = L1; run = L0; op = 4'h0; zero = L0; mem_ready = L0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++)
            cyc(tbl[i].rst, tbl[i].run, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].exp, tbl[i].cnt, "table");
        mcnt = 16'd2;
        cyc(L0, L1, 4'h0, L0, L0, E_IDLE, mcnt, "start");

        // Directed corner cases: branches both ways, store, jump, waited load
        instr(4'd13, L1, 0, 0, L1, "beq_taken");
        instr(4'd13, L0, 0, 0, L1, "beq_not");
        instr(4'd14, L1, 0, 0, L1, "bne_not");
        instr(4'd14, L0, 0, 0, L1, "bne_taken");
        instr(4'd12, L0, 0, 0, L1, "store");
        instr(4'd7,  L0, 0, 0, L1, "jump");
        instr(4'd11, L0, 1, 3, L0, "load_wait");
        instr(4'd12, L1, 2, 2, L1, "store_wait");

        for (int k = 0; k < 60; k++)
            instr(4'($urandom_range(0, 14)), rbit(), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), "random");

        cyc(L0, rbit(), 4'hF, rbit(), L1, e_fetch(L1), mcnt, "halt_fetch");
        cyc(L0, rbit(), rop(), rbit(), rbit(), E_DEC, mcnt, "halt_decode");
        for (int i = 0; i < 3; i++)
            cyc(L0, L1, rop(), rbit(), rbit(), E_HALT, mcnt, "halt_hold");
        cyc(L1, L1, rop(), rbit(), rbit(), E_HALT, mcnt, "halt_rst");
        mcnt = 16'd0;
        cyc(L0, L0, rop(), rbit(), rbit(), E_IDLE, mcnt, "post_rst");

        cyc(L0, L1, rop(), L0, L0, E_IDLE, mcnt, "memwr_idle");
        cyc(L0, L1, 4'hC, L0, L1, e_fetch(L1), mcnt, "memwr_fetch");
        cyc(L0, L1, rop(), L0, L1, E_DEC, mcnt, "memwr_decode");
        cyc(L0, L1, rop(), L0, L1, ev(L0, L0, L0, 2'd0, 3'd2, L1, L0, L0, L0, L0, L0, L0, L0, 3'd3), mcnt, "memwr_exec");
        cyc(L0, L1, rop(), L0, L0, E_MEMWR, mcnt, "memwr_wait");
        cyc(L1, L1, rop(), L0, L0, E_MEMWR, mcnt, "memwr_rst");
        cyc(L0, L0, rop(), L0, L1, E_IDLE, mcnt, "memwr_after_rst");

        cyc(L0, L1, rop(), L0, L0, E_IDLE, mcnt, "wrap_start");
        for (int i = 0; i < 16; i++)
            instr(4'd7, rbit(), int'($urandom_range(0, 1)), 0, (i != 15), "wrap_jump");
        n_total++;
        if (instr_count_b !== 4'd0 || instr_count !== 16'd16)
            $display("FAIL wrap: got %0d / %0d, expected 16 / 0", instr_count, instr_count_b);
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit 4-bit-opcode CPU datapath.
- Uses the existing opcode map and drives the existing datapath selects (alucs, selscrB, redges, memtoreg, wren, flagwrite, regwrite).
- Adds instruction-register/PC sequencing and wait states on a shared memory port (mem_ready handshake).
- Adds a halt state and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OP, 4'hF, opcode that enters HALT

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
run  input  1  start/continue execution
op  input  4  opcode field of memory read data (valid when mem_ready=1 in FETCH)
zero  input  1  ALU zero flag, combinational, valid in EXEC
mem_ready  input  1  memory access complete this cycle
imem_rd  output  1  instruction fetch request
irwrite  output  1  load instruction register
pcwrite  output  1  update PC
pcsrc  output  2  0=PC+1, 1=branch target, 2=jump target
alucs  output  3  ALU operation select
selscrB  output  1  ALU B source: 1=immediate
redges  output  1  destination register field select
memtoreg  output  1  writeback source: 1=memory data
regwrite  output  1  register file write enable
flagwrite  output  1  flag register write enable
dmem_rd  output  1  data memory read request
wren  output  1  data memory write enable
halted  output  1  FSM in HALT
state  output  3  current state code (debug)
instr_count  output  CNT_W  retired instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEMRD=4, MEMWR=5, WB=6, HALT=7.
- Reset: state=IDLE, op_q=0, instr_count=0. All outputs 0 in IDLE. rst overrides everything, including mid-instruction and HALT.
- Outputs are Moore-decoded from state and op_q. The only exceptions are irwrite/pcwrite in FETCH (gated by mem_ready) and branch pcwrite (gated by zero).
- Transitions:
  - IDLE: go to FETCH if run=1, else stay.
  - FETCH: imem_rd=1. If mem_ready=0, stay. If mem_ready=1: irwrite=1, pcwrite=1, pcsrc=0, op_q<=op, go to DECODE.
  - DECODE: no enables. Go to HALT if op_q==HALT_OP, else EXEC.
  - EXEC:
    - Ops 0-6: alucs=op_q[2:0], selscrB=0, redges=1, go to WB.
    - Ops 8-10: alucs=op_q[2:0], selscrB=1, redges=0, go to WB.
    - Op 11: alucs=2, selscrB=1, go to MEMRD.
    - Op 12: alucs=2, selscrB=1, go to MEMWR.
    - Op 13: alucs=3. pcwrite=zero, pcsrc=1. Instruction retires.
    - Op 14: alucs=3. pcwrite=~zero, pcsrc=1. Instruction retires.
    - Op 7: alucs=2, pcwrite=1, pcsrc=2. Instruction retires.
  - flagwrite=1 only in EXEC and only for ops 2,3,5,6,10.
  - MEMRD: dmem_rd=1, alucs=2, selscrB=1. Stay while mem_ready=0; go to WB on mem_ready=1.
  - MEMWR: wren=1, alucs=2, selscrB=1. Stay while mem_ready=0. On mem_ready=1 the instruction retires.
  - WB: regwrite=1 (exactly one cycle per instruction). alucs/selscrB/redges held as in EXEC. memtoreg=1 only for op 11. Instruction retires.
- Retire: instr_count+1, wrapping from all-ones to 0. Next state is FETCH if run=1, else IDLE. run is sampled only at retire and in IDLE.
- Latency with mem_ready=1 in the same cycle: R/I=4 cycles, load=5, store=4, branch/jump=3.
- Each wait cycle on mem_ready adds exactly 1 cycle; request outputs are held stable while waiting.
- Branch/jump targets are computed by the datapath from the already-incremented PC.
- HALT: halted=1, all other outputs 0. Left only via rst. The HALT opcode does not increment instr_count.
- wren and regwrite are never both 1. pcwrite never asserts outside FETCH/EXEC.

Test Plan:
- Reset then run=1, op=4'h2, mem_ready=1 -> states 1,2,3,6,1. flagwrite=1 in EXEC; regwrite=1 for 1 cycle in WB with alucs=2, redges=1; instr_count=1.
- Load op=11, mem_ready low for 3 cycles in MEMRD -> dmem_rd held 4 cycles. WB has memtoreg=1, regwrite=1. Total 8 cycles. No flagwrite.
- Op=13 with zero=1 -> pcwrite=1, pcsrc=1 in EXEC. Op=13 with zero=0 -> pcwrite=0. Op=14 gives the inverse. Both 3 cycles; instr_count +1 each.
- Store op=12 with mem_ready=1 -> wren=1 exactly 1 cycle, regwrite never 1. Op=7 -> pcsrc=2, pcwrite=1, 3 cycles.
- Op=15 -> HALT after DECODE; halted=1 persists with run=1 and instr_count unchanged. rst=1 -> IDLE, all outputs 0, count 0.
- rst asserted in MEMWR while waiting -> next cycle IDLE and wren=0. instr_count preset to 0xFFFF via 65535 retires -> next retire gives 0.
